key_expand_128: RTL and testbench

//   AES-128 key-expansion sequencer and read-side master of the rcon ROM.
//   On start, latches a 128-bit cipher key and emits round keys 0..10 in order.

---
 rtl/key_expand_128_pkg.sv | 22 ++
 rtl/key_expand_128_if.sv | 24 ++
 rtl/key_expand_128_sbox.sv | 45 ++++
 rtl/key_expand_128.sv | 117 +++++++++++
 tb/tb_key_expand_128.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_expand_128_pkg.sv
// Shared definitions for the AES-128 key expander: FSM encoding, round count,
// ROM address width and word/byte helpers.
package key_expand_128_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CALC  = 2'd2
  } state_t;

  localparam int AES_NR      = 10;
  localparam int RCON_ADDR_W = 4;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expand_128_if.sv
// Bundle of the key expander's control, round-key and rcon ROM read signals.
interface key_expand_128_if;
  import key_expand_128_pkg::*;

  logic                   start;
  logic [127:0]           key_in;
  logic [RCON_ADDR_W-1:0] rcon_addr;
  logic [31:0]            rcon_dout;
  logic [127:0]           rk;
  logic [3:0]             rk_idx;
  logic                   rk_valid;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, key_in, rcon_dout,
    output rcon_addr, rk, rk_idx, rk_valid, busy, done
  );

  modport slave (
    output start, key_in, rcon_dout,
    input  rcon_addr, rk, rk_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/key_expand_128_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform, so no lookup table is needed.
module key_expand_128_sbox
  import key_expand_128_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for a != 0, and 0 maps to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s = affine(gf_inv(a));

endmodule

// File: rtl/key_expand_128.sv
// AES-128 key-expansion sequencer: emits round keys 0..10 one at a time,
// reading each round's Rcon from an external registered ROM.
module key_expand_128
  import key_expand_128_pkg::*;
#(
  parameter int RCON_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  key_expand_128_if.master  bus
);

  localparam int WAIT_W = (RCON_LAT > 1) ? $clog2(RCON_LAT) : 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [RCON_ADDR_W-1:0] round;
  logic [127:0]           rk_q;
  logic [3:0]             idx_q;
  logic                   vld_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   accept;
  logic                   last_wait;
  logic                   last_round;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;

  // busy stays up through the done cycle, which keeps a start there from being taken
  assign accept     = (state == ST_IDLE) && bus.start && !busy_q;
  assign last_wait  = (wait_cnt == WAIT_W'(RCON_LAT - 1));
  assign last_round = (round == RCON_ADDR_W'(AES_NR));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_FETCH;
      ST_FETCH: if (last_wait) state_nxt = ST_CALC;
      ST_CALC:  state_nxt = last_round ? ST_IDLE : ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rcon_addr = '0;
    if (state != ST_IDLE) bus.rcon_addr = round;
  end

  always_ff @(posedge clk) begin
    if (rst)                                 wait_cnt <= '0;
    else if (state == ST_FETCH && !last_wait) wait_cnt <= wait_cnt + WAIT_W'(1);
    else                                     wait_cnt <= '0;
  end

  assign w0    = rk_q[127:96];
  assign w1    = rk_q[95:64];
  assign w2    = rk_q[63:32];
  assign w3    = rk_q[31:0];
  assign rot_w = rot_word(w3);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    key_expand_128_sbox u_sbox (
      .a (rot_w[31-8*g -: 8]),
      .s (sub_w[31-8*g -: 8])
    );
  end

  assign t_w = sub_w ^ bus.rcon_dout;
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  // round-key register doubles as the working key for the next round
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q   <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      round  <= '0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      if (accept) begin
        rk_q   <= bus.key_in;
        idx_q  <= '0;
        vld_q  <= 1'b1;
        busy_q <= 1'b1;
        round  <= RCON_ADDR_W'(1);
      end else if (state == ST_CALC) begin
        rk_q  <= {n0, n1, n2, n3};
        idx_q <= round;
        vld_q <= 1'b1;
        if (last_round) done_q <= 1'b1;
        else            round  <= round + RCON_ADDR_W'(1);
      end
    end
  end

  assign bus.rk       = rk_q;
  assign bus.rk_idx   = idx_q;
  assign bus.rk_valid = vld_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_key_expand_128.sv
// Scoreboard bench for key_expand_128: one instance with a 1-cycle ROM and one
// with a 2-cycle ROM share the same stimulus and are checked against a FIPS-197 model.
module tb_key_expand_128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  int           cyc = 0;
  int           nvec = 0;
  int           nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_expand_128_if if1();
  key_expand_128_if if2();

  assign if1.start  = start;
  assign if1.key_in = key_in;
  assign if2.start  = start;
  assign if2.key_in = key_in;

  key_expand_128 #(.RCON_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  key_expand_128 #(.RCON_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon_byte(input int j);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < j; i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    return rc;
  endfunction

  function automatic logic [31:0] rom_word(input logic [3:0] a);
    if (a >= 4'd1 && a <= 4'd10) return {rcon_byte(int'(a)), 24'h0};
    return 32'h0;
  endfunction

  // FIPS-197 KeyExpansion written word by word
  function automatic logic [127:0] ref_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon_byte(i/4), 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  logic [31:0] rom2_s0;
  always @(posedge clk) if1.rcon_dout <= rom_word(if1.rcon_addr);
  always @(posedge clk) begin
    rom2_s0       <= rom_word(if2.rcon_addr);
    if2.rcon_dout <= rom2_s0;
  end

  typedef struct {
    int           cyc;
    logic [3:0]   idx;
    logic [127:0] key;
    logic         done;
  } exp_t;

  exp_t         sb0[$];
  exp_t         sb1[$];
  int           idle_from [2];
  int           step [2] = '{1, 2};
  int           last_idx [2];
  logic [127:0] seen [2][11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic mon_step(input int d, input logic v, input logic dn, input logic bz,
                          input logic [3:0] ad, input logic [127:0] k, input logic [3:0] ix);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (v) begin
      if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
      if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
      if (!have) begin
        nvec++;
        nerr++;
        $display("FAIL dut%0d spurious rk_valid: got idx %0d at cycle %0d, want none", d, ix, cyc);
      end else begin
        chk($sformatf("dut%0d idx%0d strobe cycle", d, e.idx), 128'(cyc), 128'(e.cyc));
        chk($sformatf("dut%0d rk_idx", d), 128'(ix), 128'(e.idx));
        chk($sformatf("dut%0d rk idx%0d", d, e.idx), k, e.key);
        chk($sformatf("dut%0d done idx%0d", d, e.idx), 128'(dn), 128'(e.done));
        chk($sformatf("dut%0d busy at strobe", d), 128'(bz), 128'(1));
      end
      last_idx[d] = int'(ix);
      if (ix <= 4'd10) seen[d][ix] = k;
    end else begin
      chk($sformatf("dut%0d done without rk_valid", d), 128'(dn), 128'(0));
    end
    if (bz && !dn) chk($sformatf("dut%0d rcon_addr busy", d), 128'(ad), 128'(last_idx[d] + 1));
    else           chk($sformatf("dut%0d rcon_addr idle", d), 128'(ad), 128'(0));
  endtask

  always @(negedge clk) begin
    mon_step(0, if1.rk_valid, if1.done, if1.busy, if1.rcon_addr, if1.rk, if1.rk_idx);
    mon_step(1, if2.rk_valid, if2.done, if2.busy, if2.rcon_addr, if2.rk, if2.rk_idx);
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clear_seen();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 11; i++) seen[d][i] = '0;
  endtask

  // start is visible in cycle e-1 and sampled by the edge that makes cyc == e
  task automatic issue(input logic [127:0] k, output int e);
    exp_t x;
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    e      = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (e - 1 >= idle_from[d]) begin
        for (int r = 0; r <= 10; r++) begin
          x.cyc  = e + (step[d] + 1) * r;
          x.idx  = 4'(r);
          x.key  = ref_key(k, r);
          x.done = (r == 10);
          push(d, x);
        end
        idle_from[d] = e + (step[d] + 1) * 10 + 1;
      end
    end
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic chk_idle(input int d, input logic [127:0] k, input logic [3:0] ix,
                          input logic v, input logic bz, input logic dn, input logic [3:0] ad);
    chk($sformatf("dut%0d reset rk", d), k, 128'(0));
    chk($sformatf("dut%0d reset rk_idx", d), 128'(ix), 128'(0));
    chk($sformatf("dut%0d reset rk_valid", d), 128'(v), 128'(0));
    chk($sformatf("dut%0d reset busy", d), 128'(bz), 128'(0));
    chk($sformatf("dut%0d reset done", d), 128'(dn), 128'(0));
    chk($sformatf("dut%0d reset rcon_addr", d), 128'(ad), 128'(0));
  endtask

  task automatic flush_sb(input int r);
    while (sb0.size() > 0) begin
      if (sb0[0].cyc < r) chk("dut0 missed strobe before reset", 128'(1), 128'(0));
      void'(sb0.pop_front());
    end
    while (sb1.size() > 0) begin
      if (sb1[0].cyc < r) chk("dut1 missed strobe before reset", 128'(1), 128'(0));
      void'(sb1.pop_front());
    end
  endtask

  task automatic do_reset(input int ncyc);
    int r;
    @(negedge clk);
    rst = 1'b1;
    r   = cyc + 1;
    repeat (ncyc) @(negedge clk);
    flush_sb(r);
    chk_idle(0, if1.rk, if1.rk_idx, if1.rk_valid, if1.busy, if1.done, if1.rcon_addr);
    chk_idle(1, if2.rk, if2.rk_idx, if2.rk_valid, if2.busy, if2.done, if2.rcon_addr);
    rst = 1'b0;
    idle_from[0] = cyc;
    idle_from[1] = cyc;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (sb0.size() > 0 || sb1.size() > 0) begin
      chk("drain timeout pending entries", 128'(sb0.size() + sb1.size()), 128'(0));
      sb0.delete();
      sb1.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

  initial begin
    int e;
    int e2;
    last_idx[0] = 0;
    last_idx[1] = 0;
    do_reset(3);

    // FIPS-197 A.1 vector on both ROM latencies
    clear_seen();
    issue(FIPS_KEY, e);
    drain();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d fips idx0", d), seen[d][0], FIPS_KEY);
      chk($sformatf("dut%0d fips idx1", d), seen[d][1], FIPS_K1);
      chk($sformatf("dut%0d fips idx10", d), seen[d][10], FIPS_K10);
    end

    // re-pulsed start with another key during busy is ignored
    clear_seen();
    issue(FIPS_KEY, e);
    wait_cyc(e + 3);
    issue({$urandom, $urandom, $urandom, $urandom}, e2);
    drain();
    chk("dut0 repulse idx10", seen[0][10], FIPS_K10);
    chk("dut1 repulse idx10", seen[1][10], FIPS_K10);

    // reset mid-expansion, then all-zero key
    issue({$urandom, $urandom, $urandom, $urandom}, e);
    wait_cyc(e + 6);
    do_reset(1);
    repeat (4) @(negedge clk);
    clear_seen();
    issue(128'h0, e);
    drain();
    chk("dut0 zero-key idx1", seen[0][1], ZERO_K1);
    chk("dut1 zero-key idx1", seen[1][1], ZERO_K1);

    // start in the done cycle is dropped, one cycle later it is taken
    issue({$urandom, $urandom, $urandom, $urandom}, e);
    wait_cyc(e + 20 - 1);
    issue({$urandom, $urandom, $urandom, $urandom}, e2);
    issue({$urandom, $urandom, $urandom, $urandom}, e2);
    @(negedge clk);
    chk("dut0 busy after second start", 128'(if1.busy), 128'(1));
    drain();

    // randomized keys with random gaps, some landing while busy
    for (int n = 0; n < 8; n++) begin
      issue({$urandom, $urandom, $urandom, $urandom}, e);
      repeat ($urandom_range(0, 35)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
